// File: rtl/input_framer_pkg.sv
// Shared types and constants for the FFT input framer.
package input_framer_pkg;

   // Framer control states
   typedef enum logic [1:0] {
      ST_RST    = 2'd0,
      ST_CFG    = 2'd1,
      ST_STREAM = 2'd2
   } state_e;

   // Sample layout: [31:16] imaginary, [15:0] real
   localparam int SAMPLE_W = 32;
   localparam int FIELD_W  = 16;
   localparam int CFG_W    = 16;

   // Forward transform configuration word
   localparam logic [CFG_W-1:0] CFG_WORD_DEF = 16'h0001;

endpackage

// File: rtl/stream_fifo.sv
// Synchronous FIFO, no pass-through: a word written in one cycle is
// visible on o_data from the next cycle. Depth must be a power of two.
module stream_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 8
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_data,
   output logic             o_full,
   output logic             o_empty
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
   logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]            rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]            cnt_q, cnt_d;
   logic                        wr_en, rd_en;

   assign o_full  = (cnt_q == FULL_CNT);
   assign o_empty = (cnt_q == '0);
   assign wr_en   = i_push && !o_full;
   assign rd_en   = i_pop && !o_empty;
   assign o_data  = mem_q[rd_ptr_q];

   // Next storage, pointers (wrap naturally at DEPTH) and occupancy
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (wr_en) begin
         mem_d[wr_ptr_q] = i_data;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (rd_en) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({wr_en, rd_en})
         2'b10:   cnt_d = cnt_q + CNT_W'(1);
         2'b01:   cnt_d = cnt_q - CNT_W'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   // Storage is cleared on reset so the read port shows zero while idle
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         mem_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule

// File: rtl/input_framer.sv
// Buffers upstream samples, sends the FFT config word, then streams
// samples in frames of FRAME_LEN with a last marker on the final one.
// Config re-send requests are deferred to the next frame boundary.
module input_framer
   import input_framer_pkg::*;
#(
   parameter int                FRAME_LEN  = 1024,
   parameter int                FIFO_DEPTH = 8,
   parameter logic [CFG_W-1:0]  CFG_WORD   = CFG_WORD_DEF
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic [SAMPLE_W-1:0] i_data,
   input  logic                i_data_valid,
   output logic                o_data_ready,
   output logic [SAMPLE_W-1:0] o_data,
   output logic                o_data_valid,
   output logic                o_data_last,
   input  logic                i_data_ready,
   output logic [CFG_W-1:0]    o_cfg_data,
   output logic                o_cfg_valid,
   input  logic                i_cfg_ready,
   input  logic                i_cfg_req,
   output logic [15:0]         o_frame_cnt
);

   localparam int CNT_W = $clog2(FRAME_LEN);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] smp_cnt_q, smp_cnt_d;
   logic [15:0]      frame_cnt_q, frame_cnt_d;
   logic             pend_q, pend_d;

   logic fifo_full, fifo_empty;
   logic fifo_push, fifo_pop;
   logic out_xfer, cfg_xfer, last_xfer;

   // Acceptance is independent of FSM state beyond the reset hold-off
   assign fifo_push   = i_data_valid && o_data_ready;
   assign out_xfer    = o_data_valid && i_data_ready;
   assign fifo_pop    = out_xfer;
   assign cfg_xfer    = o_cfg_valid && i_cfg_ready;
   assign last_xfer   = out_xfer && (smp_cnt_q == LAST_IDX);
   assign o_data_last = o_data_valid && (smp_cnt_q == LAST_IDX);
   assign o_cfg_data  = CFG_WORD;
   assign o_frame_cnt = frame_cnt_q;

   stream_fifo #(
      .WIDTH (SAMPLE_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_push  (fifo_push),
      .i_data  (i_data),
      .i_pop   (fifo_pop),
      .o_data  (o_data),
      .o_full  (fifo_full),
      .o_empty (fifo_empty)
   );

   // State register
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) state_q <= ST_RST;
      else       state_q <= state_d;
   end

   // Next state: config first, re-config only on a frame boundary
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RST:    state_d = ST_CFG;
         ST_CFG:    if (cfg_xfer) state_d = ST_STREAM;
         ST_STREAM: if (last_xfer && pend_q) state_d = ST_CFG;
         default:   state_d = ST_RST;
      endcase
   end

   // Per-state output qualifiers
   always_comb begin
      o_cfg_valid  = 1'b0;
      o_data_valid = 1'b0;
      o_data_ready = 1'b0;
      case (state_q)
         ST_CFG: begin
            o_cfg_valid  = 1'b1;
            o_data_ready = !fifo_full;
         end
         ST_STREAM: begin
            o_data_valid = !fifo_empty;
            o_data_ready = !fifo_full;
         end
         default: ;
      endcase
   end

   // Sample/frame counters and the sticky re-send request
   always_comb begin
      smp_cnt_d   = smp_cnt_q;
      frame_cnt_d = frame_cnt_q;
      pend_d      = pend_q;
      if (out_xfer) begin
         if (smp_cnt_q == LAST_IDX) begin
            smp_cnt_d   = '0;
            frame_cnt_d = frame_cnt_q + 16'd1;
         end else begin
            smp_cnt_d = smp_cnt_q + CNT_W'(1);
         end
      end
      // Consumed only when it redirects the FSM; a pulse landing in the
      // same cycle survives for the following frame end.
      if (state_q == ST_STREAM && last_xfer && pend_q) pend_d = 1'b0;
      if (i_cfg_req) pend_d = 1'b1;
   end

   // Counter and flag registers
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         smp_cnt_q   <= '0;
         frame_cnt_q <= '0;
         pend_q      <= 1'b0;
      end else begin
         smp_cnt_q   <= smp_cnt_d;
         frame_cnt_q <= frame_cnt_d;
         pend_q      <= pend_d;
      end
   end

endmodule

// File: tb/tb_input_framer.sv
// Scoreboard bench for input_framer with FRAME_LEN=8, FIFO_DEPTH=4.
module tb_input_framer;

   localparam int FL = 8;

   logic        i_clk = 1'b0;
   logic        i_rst = 1'b1;
   logic [31:0] i_data = '0;
   logic        i_data_valid = 1'b0;
   logic        o_data_ready;
   logic [31:0] o_data;
   logic        o_data_valid;
   logic        o_data_last;
   logic        i_data_ready = 1'b0;
   logic [15:0] o_cfg_data;
   logic        o_cfg_valid;
   logic        i_cfg_ready = 1'b0;
   logic        i_cfg_req = 1'b0;
   logic [15:0] o_frame_cnt;

   input_framer #(
      .FRAME_LEN  (FL),
      .FIFO_DEPTH (4),
      .CFG_WORD   (16'h0001)
   ) dut (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_data       (i_data),
      .i_data_valid (i_data_valid),
      .o_data_ready (o_data_ready),
      .o_data       (o_data),
      .o_data_valid (o_data_valid),
      .o_data_last  (o_data_last),
      .i_data_ready (i_data_ready),
      .o_cfg_data   (o_cfg_data),
      .o_cfg_valid  (o_cfg_valid),
      .i_cfg_ready  (i_cfg_ready),
      .i_cfg_req    (i_cfg_req),
      .o_frame_cnt  (o_frame_cnt)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      logic [31:0] d;
      int          c;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        mon_e;
   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;
   int          out_idx = 0;
   int          cfg_cnt = 0;
   int          accepted = 0;
   bit          lat_chk = 1'b0;
   bit          pend_v = 1'b0;
   bit          req_pulse = 1'b0;
   logic [31:0] pend_data = '0;
   logic [31:0] seq_val = '0;

   always @(posedge i_clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic timeout(input string name);
      checks++;
      failures++;
      $display("FAIL %s timed out (cycle %0d)", name, cyc);
   endtask

   // One cycle: drive at negedge, record an input transfer due at the next edge
   task automatic tick(input bit rdy);
      @(negedge i_clk);
      i_data_valid = pend_v;
      i_data       = pend_data;
      i_data_ready = rdy;
      i_cfg_req    = req_pulse;
      req_pulse    = 1'b0;
      #1;
      if (pend_v && o_data_ready) begin
         exp_q.push_back('{d: pend_data, c: cyc});
         pend_v = 1'b0;
         accepted++;
      end
   endtask

   task automatic send(input int n, input int pv, input int pr, input bit seq);
      int sent  = 0;
      int guard = 0;
      while ((sent < n || pend_v) && guard < 20000) begin
         if (!pend_v && sent < n && int'($urandom_range(99)) < pv) begin
            pend_v    = 1'b1;
            pend_data = seq ? seq_val : $urandom;
            seq_val   = seq_val + 1;
            sent++;
         end
         tick(int'($urandom_range(99)) < pr);
         guard++;
      end
      if (guard >= 20000) timeout("send");
   endtask

   task automatic drain();
      int guard = 0;
      while ((exp_q.size() > 0 || pend_v) && guard < 200) begin
         tick(1'b1);
         guard++;
      end
      if (guard >= 200) timeout("drain");
      tick(1'b1);
   endtask

   task automatic wait_cfg(input int target);
      int guard = 0;
      while (cfg_cnt < target && guard < 50) begin
         tick(1'b1);
         guard++;
      end
      if (guard >= 50) timeout("wait_cfg");
      tick(1'b1);
      chk("cfg_count", 32'(cfg_cnt), 32'(target));
   endtask

   task automatic do_reset();
      @(negedge i_clk);
      i_rst        = 1'b1;
      i_data_valid = 1'b0;
      i_data_ready = 1'b0;
      i_cfg_req    = 1'b0;
      pend_v       = 1'b0;
      exp_q.delete();
      out_idx      = 0;
      #1;
      chk("rst_data_ready", 32'(o_data_ready), 0);
      chk("rst_data_valid", 32'(o_data_valid), 0);
      chk("rst_data_last",  32'(o_data_last), 0);
      chk("rst_cfg_valid",  32'(o_cfg_valid), 0);
      chk("rst_frame_cnt",  32'(o_frame_cnt), 0);
      chk("rst_data",       o_data, 0);
      chk("rst_cfg_data",   32'(o_cfg_data), 32'h0001);
      repeat (2) @(negedge i_clk);
      i_rst = 1'b0;
      #1;
      chk("ready_at_release", 32'(o_data_ready), 0);
      @(negedge i_clk);
      #1;
      chk("ready_after_release", 32'(o_data_ready), 1);
   endtask

   // Monitor: compares every output transfer against the scoreboard
   always begin
      @(negedge i_clk);
      #2;
      if (!i_rst) begin
         chk("frame_cnt", 32'(o_frame_cnt), 32'((out_idx / FL) % 65536));
         chk("cfg_data_overlap", 32'(o_cfg_valid & o_data_valid), 0);
         if (!o_data_valid) chk("last_idle", 32'(o_data_last), 0);
         if (o_data_valid && exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL data_valid_empty actual=valid required=no data (cycle %0d)", cyc);
         end else if (o_data_valid && i_data_ready) begin
            mon_e = exp_q.pop_front();
            chk("data", o_data, mon_e.d);
            chk("last", 32'(o_data_last), 32'((out_idx % FL) == FL - 1));
            if (lat_chk) chk("latency", 32'(cyc - mon_e.c), 1);
            out_idx++;
         end
         if (o_cfg_valid && i_cfg_ready) begin
            chk("cfg_word", 32'(o_cfg_data), 32'h0001);
            chk("cfg_frame_aligned", 32'(out_idx % FL), 0);
            cfg_cnt++;
         end
      end
   end

   initial begin
      int n;
      int base;

      // Reset release, config held off, then a single cfg transfer
      do_reset();
      chk("cfg_valid_in_cfg", 32'(o_cfg_valid), 1);
      chk("data_valid_in_cfg", 32'(o_data_valid), 0);
      tick(1'b1);
      tick(1'b1);
      chk("no_cfg_without_ready", 32'(cfg_cnt), 0);
      i_cfg_ready = 1'b1;
      wait_cfg(1);
      repeat (3) tick(1'b1);
      chk("cfg_valid_stream", 32'(o_cfg_valid), 0);
      chk("data_valid_idle", 32'(o_data_valid), 0);

      // 16 in-order samples, 1-cycle latency, two frames
      seq_val = '0;
      lat_chk = 1'b1;
      send(16, 100, 100, 1'b1);
      drain();
      lat_chk = 1'b0;
      chk("frames_after_16", 32'(o_frame_cnt), 2);

      // Backpressure: 5 offered, only 4 fit
      accepted = 0;
      base = 0;
      for (int c = 0; c < 8; c++) begin
         if (!pend_v && base < 5) begin
            pend_v    = 1'b1;
            pend_data = seq_val;
            seq_val   = seq_val + 1;
            base++;
         end
         tick(1'b0);
      end
      chk("accepted_while_full", 32'(accepted), 4);
      chk("ready_low_full", 32'(o_data_ready), 0);
      drain();
      chk("out_after_backpressure", 32'(out_idx), 21);

      // Re-send request mid-frame waits for the frame end
      n = ((FL - out_idx % FL) % FL) + 3;
      send(n, 100, 100, 1'b1);
      drain();
      base = cfg_cnt;
      req_pulse = 1'b1;
      send(10, 100, 100, 1'b1);
      drain();
      repeat (3) tick(1'b1);
      chk("one_resend", 32'(cfg_cnt), 32'(base + 1));

      // Reset mid-frame with samples still buffered
      n = ((5 - out_idx % FL) + FL) % FL;
      if (n > 0) begin
         send(n, 100, 100, 1'b1);
         drain();
      end
      send(2, 100, 0, 1'b1);
      base = cfg_cnt;
      do_reset();
      wait_cfg(base + 1);
      chk("frames_after_reset", 32'(o_frame_cnt), 0);
      send(8, 100, 100, 1'b1);
      drain();
      chk("frames_after_8", 32'(o_frame_cnt), 1);

      // Random valid/ready traffic
      send(1000, 60, 60, 1'b0);
      drain();
      chk("total_out", 32'(out_idx), 1008);
      chk("frames_total", 32'(o_frame_cnt), 126);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Absolute time limit
   initial begin
      #2000000;
      $display("FAIL global_timeout actual=running required=finished");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "timeout");
   end

endmodule
